rv_decode_issue: RTL and testbench

Decode/issue stage placed directly upstream of the ALU and register file. It accepts one 32-bit RV32I instruction per cycle and decodes R-type ALU, I-type ALU and conditional-branch instructions. Results go into a registered EX-bound bundle: ALU op code, register addresses, immediate and write enable. It handles valid/ready backpressure and flush, and can optionally hold a register scoreboard that stalls issue on RAW/WAW hazards until writeback.

---
 rtl/rv_decode_issue.sv | 172 +++++++++++++++++
 tb/tb_rv_decode_issue.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_decode_issue.sv
// RV32I decode/issue stage: decodes OP, OP-IMM and BRANCH into a registered EX bundle.
// Optional busy-register scoreboard (RAW/WAW stall until writeback) under `DECODE_SCOREBOARD_EN.
module rv_decode_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_valid_i,
  output logic        inst_ready_o,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  output logic        ex_valid_o,
  input  logic        ex_ready_i,
  output logic [3:0]  ex_alu_op_o,
  output logic [4:0]  ex_rs1_o,
  output logic [4:0]  ex_rs2_o,
  output logic [4:0]  ex_rd_o,
  output logic [31:0] ex_imm_o,
  output logic        ex_use_imm_o,
  output logic        ex_wen_o,
  output logic        ex_branch_o,
  output logic        ex_illegal_o,
  output logic [31:0] ex_pc_o,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i
);
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        wen;
    logic        branch;
    logic        illegal;
    logic [31:0] pc;
  } bundle_t;

  bundle_t    dec, bundle_q, bundle_d;
  logic       ex_valid_q, ex_valid_d;
  logic       uses_rs1, uses_rs2, hazard, accept;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];

  always_comb begin
    dec         = '0;
    dec.rs1     = inst_i[19:15];
    dec.rs2     = inst_i[24:20];
    dec.rd      = inst_i[11:7];
    dec.pc      = pc_i;
    dec.illegal = 1'b1;
    uses_rs1    = 1'b0;
    uses_rs2    = 1'b0;
    case (inst_i[6:0])
      OPC_OP: begin
        if (funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          dec.illegal = 1'b0;
          dec.alu_op  = {funct7[5], funct3};
          dec.wen     = 1'b1;
          uses_rs1    = 1'b1;
          uses_rs2    = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        if ((funct3 == 3'b001 && funct7 == 7'h00) ||
            (funct3 == 3'b101 && (funct7 == 7'h00 || funct7 == 7'h20)) ||
            (funct3 != 3'b001 && funct3 != 3'b101)) begin
          dec.illegal = 1'b0;
          dec.alu_op  = (funct3 == 3'b101 && funct7 == 7'h20) ? 4'b1101 : {1'b0, funct3};
          dec.imm     = (funct3 == 3'b001 || funct3 == 3'b101) ? {27'b0, inst_i[24:20]}
                                                             : {{20{inst_i[31]}}, inst_i[31:20]};
          dec.use_imm = 1'b1;
          dec.wen     = 1'b1;
          uses_rs1    = 1'b1;
        end
      end
      OPC_BRANCH: begin
        dec.illegal = 1'b0;
        case (funct3)
          3'b000:  dec.alu_op = 4'b1001;
          3'b001:  dec.alu_op = 4'b1010;
          3'b100:  dec.alu_op = 4'b0010;
          3'b101:  dec.alu_op = 4'b1100;
          3'b110:  dec.alu_op = 4'b0011;
          3'b111:  dec.alu_op = 4'b1011;
          default: dec.illegal = 1'b1;
        endcase
        if (!dec.illegal) begin
          dec.branch = 1'b1;
          dec.imm    = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
          uses_rs1   = 1'b1;
          uses_rs2   = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.rd == 5'd0) dec.wen = 1'b0;
  end

`ifdef DECODE_SCOREBOARD_EN
  logic [31:0] busy_q, busy_d, wb_clr, busy_eff;

  // Retiring registers are bypassed so a dependent instruction issues in the writeback cycle.
  always_comb begin
    wb_clr = '0;
    if (wb_valid_i) wb_clr[wb_rd_i] = 1'b1;
    busy_eff = busy_q & ~wb_clr;
    hazard   = (uses_rs1 & busy_eff[dec.rs1]) | (uses_rs2 & busy_eff[dec.rs2]) |
               (dec.wen & busy_eff[dec.rd]);
    busy_d   = busy_eff;
    if (flush_i && ex_valid_q && bundle_q.wen) busy_d[bundle_q.rd] = 1'b0;
    if (accept && dec.wen) busy_d[dec.rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end
`else
  logic unused_sb;
  assign unused_sb = ^{wb_valid_i, wb_rd_i, uses_rs1, uses_rs2};
  assign hazard    = 1'b0;
`endif

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid never
  // depends on ready, and a held bundle stays stable until it is taken or flushed.
  assign inst_ready_o = !reset && !flush_i && (!ex_valid_q || ex_ready_i) && !hazard;
  assign accept       = inst_valid_i && inst_ready_o;

  always_comb begin
    bundle_d   = bundle_q;
    ex_valid_d = ex_valid_q;
    if (flush_i) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      bundle_d   = dec;
      ex_valid_d = 1'b1;
    end else if (ex_ready_i) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bundle_q   <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      bundle_q   <= bundle_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  assign ex_valid_o   = ex_valid_q;
  assign ex_alu_op_o  = bundle_q.alu_op;
  assign ex_rs1_o     = bundle_q.rs1;
  assign ex_rs2_o     = bundle_q.rs2;
  assign ex_rd_o      = bundle_q.rd;
  assign ex_imm_o     = bundle_q.imm;
  assign ex_use_imm_o = bundle_q.use_imm;
  assign ex_wen_o     = bundle_q.wen;
  assign ex_branch_o  = bundle_q.branch;
  assign ex_illegal_o = bundle_q.illegal;
  assign ex_pc_o      = bundle_q.pc;
endmodule

// File: tb/tb_rv_decode_issue.sv
// Self-checking bench for rv_decode_issue; expected EX bundles queue up at acceptance
// and are compared when the bundle is consumed. Scoreboard scenarios follow `DECODE_SCOREBOARD_EN.
module tb_rv_decode_issue;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_valid_i = 1'b0;
  logic        inst_ready_o;
  logic [31:0] inst_i = '0;
  logic [31:0] pc_i = '0;
  logic        flush_i = 1'b0;
  logic        ex_valid_o;
  logic        ex_ready_i;
  logic [3:0]  ex_alu_op_o;
  logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [31:0] ex_imm_o, ex_pc_o;
  logic        ex_use_imm_o, ex_wen_o, ex_branch_o, ex_illegal_o;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;

  logic        man_ready = 1'b0, rand_ready = 1'b0, rand_bp = 1'b0;
  logic        man_wb_v = 1'b0, auto_wb_v = 1'b0, auto_wb = 1'b0, pend_v = 1'b0;
  logic [4:0]  man_wb_rd = '0, auto_wb_rd = '0, pend_rd = '0;

  int checks = 0;
  int passed = 0;
  logic [86:0] exp_q[$];
  logic [31:0] t_inst[11];
  logic [54:0] t_exp[11];

  assign ex_ready_i = rand_bp ? rand_ready : man_ready;
  assign wb_valid_i = man_wb_v | auto_wb_v;
  assign wb_rd_i    = man_wb_v ? man_wb_rd : auto_wb_rd;

  wire [86:0] act_bundle = {ex_alu_op_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_imm_o,
                            ex_use_imm_o, ex_wen_o, ex_branch_o, ex_illegal_o, ex_pc_o};

  rv_decode_issue dut (
    .clk(clk), .reset(reset), .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
    .inst_i(inst_i), .pc_i(pc_i), .flush_i(flush_i), .ex_valid_o(ex_valid_o),
    .ex_ready_i(ex_ready_i), .ex_alu_op_o(ex_alu_op_o), .ex_rs1_o(ex_rs1_o),
    .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o), .ex_imm_o(ex_imm_o),
    .ex_use_imm_o(ex_use_imm_o), .ex_wen_o(ex_wen_o), .ex_branch_o(ex_branch_o),
    .ex_illegal_o(ex_illegal_o), .ex_pc_o(ex_pc_o), .wb_valid_i(wb_valid_i),
    .wb_rd_i(wb_rd_i)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [54:0] mk(input logic [3:0] op, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [4:0] rd,
                                     input logic [31:0] imm, input logic ui, input logic wen,
                                     input logic br, input logic ill);
    return {op, rs1, rs2, rd, imm, ui, wen, br, ill};
  endfunction

  // scoreboard / monitor: compare each consumed bundle against the queue head
  always @(negedge clk) begin
    pend_v = 1'b0;
    if (!reset && ex_valid_o && ex_ready_i && !flush_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL bundle_unexpected: got %h, expected none", act_bundle);
      end else begin
        logic [86:0] e;
        e = exp_q.pop_front();
        if (act_bundle !== e) $display("FAIL bundle: got %h expected %h", act_bundle, e);
        else passed++;
      end
      pend_v  = ex_wen_o;
      pend_rd = ex_rd_o;
    end
  end

  // writeback model: retire a consumed writing bundle one cycle later
  always @(posedge clk) begin
    #1;
    auto_wb_v  = auto_wb && pend_v;
    auto_wb_rd = pend_rd;
    rand_ready = 1'($urandom_range(0, 1));
  end

  // driver tasks
  task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input logic [54:0] e,
                       input bit push, output int waited);
    inst_valid_i = 1'b1;
    inst_i = inst;
    pc_i = pc;
    #1;
    waited = 0;
    while (!inst_ready_o && waited < 60) begin
      @(posedge clk);
      #2;
      waited++;
    end
    if (!inst_ready_o) begin
      checks++;
      $display("FAIL issue_timeout: inst %h ready %b, required 1", inst, inst_ready_o);
    end else if (push) begin
      exp_q.push_back({e, pc});
    end
    @(posedge clk);
    #1;
    inst_valid_i = 1'b0;
  endtask

  task automatic wb_pulse(input logic [4:0] rd);
    man_wb_rd = rd;
    man_wb_v = 1'b1;
    @(posedge clk);
    #1;
    man_wb_v = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain;
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) $display("FAIL drain: %0d bundles outstanding, required 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    inst_valid_i = 1'b1;
    inst_i = 32'h002081B3;
    idle(2);
    checks++;
    if (inst_ready_o !== 1'b0) $display("FAIL reset_ready: got %b required 0", inst_ready_o);
    else passed++;
    checks++;
    if (ex_valid_o !== 1'b0) $display("FAIL reset_valid: got %b required 0", ex_valid_o);
    else passed++;
    checks++;
    if (act_bundle !== 87'd0) $display("FAIL reset_fields: got %h required 0", act_bundle);
    else passed++;
    inst_valid_i = 1'b0;
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_decode_b2b;
    int w, total = 0;
    man_ready = 1'b1;
    auto_wb = 1'b1;
    for (int i = 0; i < 11; i++) begin
      issue(t_inst[i], 32'h1000 + 32'(i * 4), t_exp[i], 1'b1, w);
      total += w;
    end
    drain();
`ifndef DECODE_SCOREBOARD_EN
    checks++;
    if (total != 0) $display("FAIL b2b_throughput: %0d stall cycles, required 0", total);
    else passed++;
`endif
    idle(3);
  endtask

  task automatic test_backpressure;
    int w;
    logic [86:0] held;
    man_ready = 1'b0;
    held = {t_exp[0], 32'h0000_0100};
    issue(t_inst[0], 32'h0000_0100, t_exp[0], 1'b1, w);
    for (int c = 0; c < 3; c++) begin
      inst_valid_i = 1'b1;
      inst_i = t_inst[1];
      #1;
      checks++;
      if (inst_ready_o !== 1'b0) $display("FAIL bp_ready: cycle %0d got %b required 0", c, inst_ready_o);
      else passed++;
      checks++;
      if (ex_valid_o !== 1'b1 || act_bundle !== held)
        $display("FAIL bp_hold: cycle %0d got %b/%h required 1/%h", c, ex_valid_o, act_bundle, held);
      else passed++;
      @(posedge clk);
      #1;
    end
    inst_valid_i = 1'b0;
    man_ready = 1'b1;
    idle(1);
    checks++;
    if (ex_valid_o !== 1'b0) $display("FAIL bp_release: ex_valid %b required 0", ex_valid_o);
    else passed++;
    drain();
    idle(3);
  endtask

  task automatic test_hazard;
    int w;
    int seen;
    auto_wb = 1'b0;
    man_ready = 1'b1;
    issue(32'h00500093, 32'h200, t_exp[9], 1'b1, w);
    inst_valid_i = 1'b1;
    inst_i = 32'h002081B3;
    pc_i = 32'h204;
    #1;
`ifdef DECODE_SCOREBOARD_EN
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      if (inst_ready_o) seen++;
      @(posedge clk);
      #2;
    end
    checks++;
    if (seen != 0) $display("FAIL raw_stall: ready high %0d cycles, required 0", seen);
    else passed++;
    man_wb_rd = 5'd1;
    man_wb_v = 1'b1;
    #1;
`endif
    checks++;
    if (inst_ready_o !== 1'b1) $display("FAIL raw_issue: ready %b required 1", inst_ready_o);
    else begin
      passed++;
      exp_q.push_back({t_exp[0], 32'h204});
    end
    @(posedge clk);
    #1;
    inst_valid_i = 1'b0;
    man_wb_v = 1'b0;
    drain();
    wb_pulse(5'd3);
    idle(2);
  endtask

  task automatic test_flush;
    int w;
    man_ready = 1'b0;
    auto_wb = 1'b0;
    issue(32'h00500093, 32'h300, t_exp[9], 1'b0, w);
    flush_i = 1'b1;
    #1;
    checks++;
    if (inst_ready_o !== 1'b0) $display("FAIL flush_ready: got %b required 0", inst_ready_o);
    else passed++;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    checks++;
    if (ex_valid_o !== 1'b0) $display("FAIL flush_valid: got %b required 0", ex_valid_o);
    else passed++;
    issue(32'h002081B3, 32'h304, t_exp[0], 1'b1, w);
    checks++;
    if (w != 0) $display("FAIL flush_busy_clear: waited %0d cycles required 0", w);
    else passed++;
    man_ready = 1'b1;
    drain();
    wb_pulse(5'd3);
    idle(2);
  endtask

  task automatic test_midstream_reset;
    int w;
    man_ready = 1'b0;
    issue(32'h00500093, 32'h400, t_exp[9], 1'b0, w);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    checks++;
    if (ex_valid_o !== 1'b0 || act_bundle !== 87'd0)
      $display("FAIL midreset: got %b/%h required 0/0", ex_valid_o, act_bundle);
    else passed++;
    issue(32'h002081B3, 32'h404, t_exp[0], 1'b1, w);
    checks++;
    if (w != 0) $display("FAIL midreset_busy: waited %0d cycles required 0", w);
    else passed++;
    man_ready = 1'b1;
    drain();
    wb_pulse(5'd3);
    idle(2);
  endtask

  task automatic test_random;
    int w, k;
    auto_wb = 1'b1;
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 10);
      issue(t_inst[k], {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, t_exp[k], 1'b1, w);
    end
    drain();
    rand_bp = 1'b0;
    man_ready = 1'b1;
    idle(3);
  endtask

  initial begin
    t_inst[0]  = 32'h002081B3; t_exp[0]  = mk(4'h0, 5'd1, 5'd2,  5'd3,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0);
    t_inst[1]  = 32'h402081B3; t_exp[1]  = mk(4'h8, 5'd1, 5'd2,  5'd3,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0);
    t_inst[2]  = 32'h40235293; t_exp[2]  = mk(4'hD, 5'd6, 5'd2,  5'd5,  32'h2,        1'b1, 1'b1, 1'b0, 1'b0);
    t_inst[3]  = 32'hFE20CEE3; t_exp[3]  = mk(4'h2, 5'd1, 5'd2,  5'd29, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b1, 1'b0);
    t_inst[4]  = 32'h0000007F; t_exp[4]  = mk(4'h0, 5'd0, 5'd0,  5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b1);
    t_inst[5]  = 32'h00000033; t_exp[5]  = mk(4'h0, 5'd0, 5'd0,  5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0);
    t_inst[6]  = 32'hFFF0F213; t_exp[6]  = mk(4'h7, 5'd1, 5'd31, 5'd4,  32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    t_inst[7]  = 32'h402091B3; t_exp[7]  = mk(4'h0, 5'd1, 5'd2,  5'd3,  32'h0,        1'b0, 1'b0, 1'b0, 1'b1);
    t_inst[8]  = 32'hFE20AEE3; t_exp[8]  = mk(4'h0, 5'd1, 5'd2,  5'd29, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1);
    t_inst[9]  = 32'h00500093; t_exp[9]  = mk(4'h0, 5'd0, 5'd5,  5'd1,  32'h5,        1'b1, 1'b1, 1'b0, 1'b0);
    t_inst[10] = 32'h0020F463; t_exp[10] = mk(4'hB, 5'd1, 5'd2,  5'd8,  32'h8,        1'b0, 1'b0, 1'b1, 1'b0);

    test_reset();
    test_decode_b2b();
    test_backpressure();
    test_hazard();
    test_flush();
    test_midstream_reset();
    test_random();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
